spart_bus_responder: RTL and testbench

//  SPART-side responder for the processor I/O bus (iocs/iorw/ioaddr/databus) that the driver initiates.

---
 rtl/spart_bus_responder.sv | 132 +++++++++++++
 tb/tb_spart_bus_responder.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spart_bus_responder.sv
// SPART bus-side responder: register decode on the processor I/O bus, TX/RX byte FIFOs,
// 16x baud-enable generator and the byte handshakes to the TX/RX shift cores.
module spart_bus_responder #(
  parameter int          TX_DEPTH    = 4,
  parameter int          RX_DEPTH    = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'h0145
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       baud_en
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TPW = TAW + 1;
  localparam int RPW = RAW + 1;

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DB_LO  = 2'b10;
  localparam logic [1:0] ADDR_DB_HI  = 2'b11;

  logic [7:0]     tx_mem [TX_DEPTH];
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [TAW:0]   tx_wr_ptr, tx_rd_ptr, tx_wr_nxt, tx_rd_nxt;
  logic [RAW:0]   rx_wr_ptr, rx_rd_ptr, rx_wr_nxt, rx_rd_nxt;
  logic [15:0]    divisor, div_nxt, baud_cnt;
  logic           ovr;
  logic [7:0]     rd_data;

  logic rd_cyc, wr_cyc;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_pop, tx_push, rx_pop, rx_push, rx_overrun, status_rd, db_wr;

  assign rd_cyc = iocs & iorw;
  assign wr_cyc = iocs & ~iorw;

  // The extra wrap bit separates full (same index, different lap) from empty.
  assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
  assign tx_full  = (tx_wr_ptr[TAW] != tx_rd_ptr[TAW]) &&
                    (tx_wr_ptr[TAW-1:0] == tx_rd_ptr[TAW-1:0]);
  assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full  = (rx_wr_ptr[RAW] != rx_rd_ptr[RAW]) &&
                    (rx_wr_ptr[RAW-1:0] == rx_rd_ptr[RAW-1:0]);

  // Skipping the cycle right after a start hides the TX core's one-cycle tx_busy latency.
  assign tx_pop     = !tx_empty && !tx_busy && !tx_start;
  assign tx_push    = wr_cyc && (ioaddr == ADDR_DATA) && (!tx_full || tx_pop);
  assign rx_pop     = rd_cyc && (ioaddr == ADDR_DATA) && !rx_empty;
  assign rx_push    = rx_valid && (!rx_full || rx_pop);
  assign rx_overrun = rx_valid && rx_full && !rx_pop;
  assign status_rd  = rd_cyc && (ioaddr == ADDR_STATUS);
  assign db_wr      = wr_cyc && ioaddr[1];

  assign tx_wr_nxt = tx_wr_ptr + TPW'(tx_push);
  assign tx_rd_nxt = tx_rd_ptr + TPW'(tx_pop);
  assign rx_wr_nxt = rx_wr_ptr + RPW'(rx_push);
  assign rx_rd_nxt = rx_rd_ptr + RPW'(rx_pop);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    rd_data = 8'h00;
    unique case (ioaddr)
      ADDR_DATA:   rd_data = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr[RAW-1:0]];
      ADDR_STATUS: rd_data = {5'b0, ovr, tbr, rda};
      ADDR_DB_LO:  rd_data = divisor[7:0];
      ADDR_DB_HI:  rd_data = divisor[15:8];
    endcase
  end

  assign databus = rd_cyc ? rd_data : 8'bz;

  always_comb begin
    div_nxt = divisor;
    if (wr_cyc && (ioaddr == ADDR_DB_LO)) div_nxt[7:0]  = databus;
    if (wr_cyc && (ioaddr == ADDR_DB_HI)) div_nxt[15:8] = databus;
  end

  assign baud_en = (baud_cnt == 16'd0);

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      ovr       <= 1'b0;
      rda       <= 1'b0;
      tbr       <= 1'b1;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      divisor   <= DEFAULT_DIV;
      baud_cnt  <= DEFAULT_DIV;
    end else begin
      tx_wr_ptr <= tx_wr_nxt;
      tx_rd_ptr <= tx_rd_nxt;
      rx_wr_ptr <= rx_wr_nxt;
      rx_rd_ptr <= rx_rd_nxt;
      rda       <= (rx_wr_nxt != rx_rd_nxt);
      tbr       <= !((tx_wr_nxt[TAW] != tx_rd_nxt[TAW]) &&
                     (tx_wr_nxt[TAW-1:0] == tx_rd_nxt[TAW-1:0]));
      // An overrun on the same edge as a status read wins over the clear.
      if (rx_overrun)     ovr <= 1'b1;
      else if (status_rd) ovr <= 1'b0;
      tx_start <= tx_pop;
      if (tx_pop) tx_data <= tx_mem[tx_rd_ptr[TAW-1:0]];
      divisor <= div_nxt;
      if (db_wr)                  baud_cnt <= div_nxt;
      else if (baud_cnt == 16'd0) baud_cnt <= divisor;
      else                        baud_cnt <= baud_cnt - 16'd1;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr[TAW-1:0]] <= databus;
    if (rx_push) rx_mem[rx_wr_ptr[RAW-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_spart_bus_responder.sv
// Bench for spart_bus_responder: directed scenarios plus randomized traffic checked
// against a queue-based model of the register/FIFO/baud rules.
module tb_spart_bus_responder;

  localparam int          TXD     = 4;
  localparam int          RXD     = 4;
  localparam logic [15:0] DEF_DIV = 16'h0145;

  logic       clk = 1'b0;
  logic       rst, iocs, iorw, tx_busy, rx_valid;
  logic [1:0] ioaddr;
  logic [7:0] wdata, rx_data;
  wire  [7:0] databus;
  logic       rda, tbr, tx_start, baud_en;
  logic [7:0] tx_data;

  assign databus = (iocs && !iorw) ? wdata : 8'bz;

  spart_bus_responder #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .DEFAULT_DIV(DEF_DIV)) dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
    .rda(rda), .tbr(tbr), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .baud_en(baud_en)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every TX start the DUT issues, with the cycle it happened in.
  logic [7:0] tx_seen[$];
  int         tx_seen_cyc[$];
  always @(negedge clk) begin
    if (tx_start) begin
      tx_seen.push_back(tx_data);
      tx_seen_cyc.push_back(cyc);
    end
  end

  // Reference model: FIFO contents as queues, bytes issued to the TX core in order.
  logic [7:0]  m_rx[$];
  logic [7:0]  m_tx[$];
  logic [7:0]  m_tx_out[$];
  bit          m_ovr;
  bit          m_last_start;
  logic [15:0] m_div;

  function automatic logic [7:0] model_read(input logic [1:0] a);
    bit r, t;
    r = (m_rx.size() > 0);
    t = (m_tx.size() < TXD);
    case (a)
      2'd0:    return r ? m_rx[0] : 8'h00;
      2'd1:    return {5'b0, m_ovr, t, r};
      2'd2:    return m_div[7:0];
      default: return m_div[15:8];
    endcase
  endfunction

  task automatic model_reset();
    m_rx.delete();
    m_tx.delete();
    m_tx_out.delete();
    m_ovr        = 1'b0;
    m_last_start = 1'b0;
    m_div        = DEF_DIV;
    tx_seen.delete();
    tx_seen_cyc.delete();
  endtask

  task automatic do_reset();
    iocs = 1'b0; iorw = 1'b0; ioaddr = 2'd0; wdata = 8'h00; rx_valid = 1'b0; rx_data = 8'h00;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One bus cycle: drive, sample the read value mid-cycle, advance the model and the clock.
  task automatic step(input logic cs, input logic rw, input logic [1:0] a, input logic [7:0] wd,
                      input logic rv, input logic [7:0] rb, output logic [7:0] rd);
    bit issue, rd_pop;
    iocs = cs; iorw = rw; ioaddr = a; wdata = wd; rx_valid = rv; rx_data = rb;
    #1 rd = databus;
    issue  = (m_tx.size() > 0) && !tx_busy && !m_last_start;
    rd_pop = cs && rw && (a == 2'd0) && (m_rx.size() > 0);
    if (issue) m_tx_out.push_back(m_tx.pop_front());
    if (cs && !rw && (a == 2'd0) && (m_tx.size() < TXD)) m_tx.push_back(wd);
    if (cs && rw && (a == 2'd1)) m_ovr = 1'b0;
    if (rd_pop) void'(m_rx.pop_front());
    if (rv) begin
      if (m_rx.size() < RXD) m_rx.push_back(rb);
      else                   m_ovr = 1'b1;
    end
    if (cs && !rw && (a == 2'd2)) m_div[7:0]  = wd;
    if (cs && !rw && (a == 2'd3)) m_div[15:8] = wd;
    m_last_start = issue;
    @(posedge clk); #1;
    iocs = 1'b0; iorw = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    logic [7:0] d;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00, d);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] v);
    logic [7:0] d;
    step(1'b1, 1'b0, a, v, 1'b0, 8'h00, d);
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [7:0] v);
    step(1'b1, 1'b1, a, 8'h00, 1'b0, 8'h00, v);
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    logic [7:0] d;
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, b, d);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    int first, second;
    tx_busy = 1'b0;
    do_reset();
    n_cmp++; if (rda !== 1'b0)      begin n_bad++; $display("FAIL reset_rda: got %b want 0", rda); end
    n_cmp++; if (tbr !== 1'b1)      begin n_bad++; $display("FAIL reset_tbr: got %b want 1", tbr); end
    n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    n_cmp++; if (baud_en !== 1'b0)  begin n_bad++; $display("FAIL reset_baud_en: got %b want 0", baud_en); end
    bus_rd(2'd1, v);
    n_cmp++; if (v !== 8'h02) begin n_bad++; $display("FAIL reset_status: got %h want 02", v); end
    bus_rd(2'd2, v);
    n_cmp++; if (v !== 8'h45) begin n_bad++; $display("FAIL reset_db_lo: got %h want 45", v); end
    bus_rd(2'd3, v);
    n_cmp++; if (v !== 8'h01) begin n_bad++; $display("FAIL reset_db_hi: got %h want 01", v); end
    first = -1; second = -1;
    for (int i = 0; i < 800 && second < 0; i++) begin
      idle(1);
      if (baud_en === 1'b1) begin
        if (first < 0) first = i; else second = i;
      end
    end
    n_cmp++;
    if (second < 0 || (second - first) != int'(DEF_DIV) + 1) begin
      n_bad++; $display("FAIL reset_baud_period: got %0d want %0d", second - first, int'(DEF_DIV) + 1);
    end
  endtask

  task automatic test_tx_basic();
    tx_busy = 1'b0;
    do_reset();
    bus_wr(2'd0, 8'hA5);
    bus_wr(2'd0, 8'h3C);
    idle(10);
    n_cmp++;
    if (tx_seen.size() != 2) begin
      n_bad++; $display("FAIL tx_basic_count: got %0d want 2", tx_seen.size());
    end else begin
      n_cmp++; if (tx_seen[0] !== 8'hA5) begin n_bad++; $display("FAIL tx_basic_b0: got %h want a5", tx_seen[0]); end
      n_cmp++; if (tx_seen[1] !== 8'h3C) begin n_bad++; $display("FAIL tx_basic_b1: got %h want 3c", tx_seen[1]); end
      n_cmp++;
      if (tx_seen_cyc[1] - tx_seen_cyc[0] < 2) begin
        n_bad++; $display("FAIL tx_basic_gap: got %0d want >=2", tx_seen_cyc[1] - tx_seen_cyc[0]);
      end
    end
  endtask

  task automatic test_tx_full();
    logic [7:0] exp_b;
    do_reset();
    tx_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus_wr(2'd0, 8'hC1 + 8'(k));
      n_cmp++;
      if (tbr !== ((k < 3) ? 1'b1 : 1'b0)) begin
        n_bad++; $display("FAIL tx_full_tbr%0d: got %b want %b", k, tbr, (k < 3));
      end
    end
    tx_busy = 1'b0;
    idle(20);
    n_cmp++;
    if (tx_seen.size() != 4) begin
      n_bad++; $display("FAIL tx_full_count: got %0d want 4", tx_seen.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        exp_b = 8'hC1 + 8'(k);
        n_cmp++;
        if (tx_seen[k] !== exp_b) begin
          n_bad++; $display("FAIL tx_full_b%0d: got %h want %h", k, tx_seen[k], exp_b);
        end
      end
    end
    n_cmp++; if (tbr !== 1'b1) begin n_bad++; $display("FAIL tx_full_drained_tbr: got %b want 1", tbr); end
  endtask

  // Full FIFO, busy released on the same cycle as a write: the pop frees room for the write.
  task automatic test_back_to_back();
    logic [7:0] exp_b[5];
    do_reset();
    tx_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_b[k] = 8'($urandom);
      bus_wr(2'd0, exp_b[k]);
    end
    tx_busy = 1'b0;
    exp_b[4] = 8'hD5;
    bus_wr(2'd0, 8'hD5);
    n_cmp++; if (tbr !== 1'b0) begin n_bad++; $display("FAIL b2b_tbr: got %b want 0", tbr); end
    idle(20);
    n_cmp++;
    if (tx_seen.size() != 5) begin
      n_bad++; $display("FAIL b2b_count: got %0d want 5", tx_seen.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_cmp++;
        if (tx_seen[k] !== exp_b[k]) begin
          n_bad++; $display("FAIL b2b_b%0d: got %h want %h", k, tx_seen[k], exp_b[k]);
        end
      end
      for (int k = 1; k < 5; k++) begin
        n_cmp++;
        if (tx_seen_cyc[k] - tx_seen_cyc[k-1] < 2) begin
          n_bad++; $display("FAIL b2b_gap%0d: got %0d want >=2", k, tx_seen_cyc[k] - tx_seen_cyc[k-1]);
        end
      end
    end
  endtask

  task automatic test_tx_random();
    do_reset();
    for (int i = 0; i < 100; i++) begin
      tx_busy = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1) bus_wr(2'd0, 8'($urandom));
      else                           idle(1);
      n_cmp++;
      if (tbr !== (m_tx.size() < TXD)) begin
        n_bad++; $display("FAIL tx_rand_tbr@%0d: got %b want %b", i, tbr, (m_tx.size() < TXD));
      end
      n_cmp++;
      if (tx_start !== m_last_start) begin
        n_bad++; $display("FAIL tx_rand_start@%0d: got %b want %b", i, tx_start, m_last_start);
      end
    end
    tx_busy = 1'b0;
    idle(20);
    n_cmp++;
    if (tx_seen.size() != m_tx_out.size()) begin
      n_bad++; $display("FAIL tx_rand_count: got %0d want %0d", tx_seen.size(), m_tx_out.size());
    end else begin
      for (int k = 0; k < m_tx_out.size(); k++) begin
        n_cmp++;
        if (tx_seen[k] !== m_tx_out[k]) begin
          n_bad++; $display("FAIL tx_rand_b%0d: got %h want %h", k, tx_seen[k], m_tx_out[k]);
        end
      end
    end
  endtask

  task automatic test_rx_overrun();
    logic [7:0] v;
    logic [7:0] exp_v[5];
    exp_v = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h00};
    tx_busy = 1'b0;
    do_reset();
    for (int k = 0; k < 5; k++) rx_pulse(8'h11 + 8'(k));
    n_cmp++; if (rda !== 1'b1) begin n_bad++; $display("FAIL ovr_rda: got %b want 1", rda); end
    bus_rd(2'd1, v);
    n_cmp++; if (v !== 8'h07) begin n_bad++; $display("FAIL ovr_status: got %h want 07", v); end
    for (int k = 0; k < 5; k++) begin
      bus_rd(2'd0, v);
      n_cmp++;
      if (v !== exp_v[k]) begin n_bad++; $display("FAIL ovr_read%0d: got %h want %h", k, v, exp_v[k]); end
    end
    bus_rd(2'd1, v);
    n_cmp++; if (v !== 8'h02) begin n_bad++; $display("FAIL ovr_status_after: got %h want 02", v); end
    n_cmp++; if (rda !== 1'b0) begin n_bad++; $display("FAIL ovr_rda_after: got %b want 0", rda); end
  endtask

  task automatic test_rx_same_edge();
    logic [7:0] v, e, nb;
    do_reset();
    for (int k = 0; k < RXD; k++) rx_pulse(8'($urandom));
    e  = model_read(2'd0);
    nb = 8'($urandom);
    step(1'b1, 1'b1, 2'd0, 8'h00, 1'b1, nb, v);
    n_cmp++; if (v !== e) begin n_bad++; $display("FAIL same_edge_read: got %h want %h", v, e); end
    // Status read colliding with an overrun returns the old flag and leaves ovr set.
    step(1'b1, 1'b1, 2'd1, 8'h00, 1'b0, 8'h00, v);
    n_cmp++; if (v !== 8'h03) begin n_bad++; $display("FAIL same_edge_no_ovr: got %h want 03", v); end
    step(1'b1, 1'b1, 2'd1, 8'h00, 1'b1, 8'($urandom), v);
    n_cmp++; if (v !== 8'h03) begin n_bad++; $display("FAIL stat_vs_ovr_read: got %h want 03", v); end
    bus_rd(2'd1, v);
    n_cmp++; if (v !== 8'h07) begin n_bad++; $display("FAIL stat_vs_ovr_set: got %h want 07", v); end
    for (int k = 0; k < RXD + 1; k++) begin
      e = model_read(2'd0);
      bus_rd(2'd0, v);
      n_cmp++; if (v !== e) begin n_bad++; $display("FAIL same_edge_drain%0d: got %h want %h", k, v, e); end
    end
    n_cmp++; if (v !== 8'h00) begin n_bad++; $display("FAIL same_edge_empty: got %h want 00", v); end
  endtask

  task automatic test_rx_random();
    logic [7:0] v, e;
    logic [1:0] a;
    bit         cs, rv;
    do_reset();
    for (int i = 0; i < 150; i++) begin
      cs = ($urandom_range(0, 1) == 1);
      a  = ($urandom_range(0, 3) == 0) ? 2'd1 : 2'd0;
      rv = ($urandom_range(0, 9) < 4);
      e  = model_read(a);
      step(cs, 1'b1, a, 8'h00, rv, 8'($urandom), v);
      if (cs) begin
        n_cmp++;
        if (v !== e) begin n_bad++; $display("FAIL rx_rand_read@%0d a=%0d: got %h want %h", i, a, v, e); end
      end
      n_cmp++;
      if (rda !== (m_rx.size() > 0)) begin
        n_bad++; $display("FAIL rx_rand_rda@%0d: got %b want %b", i, rda, (m_rx.size() > 0));
      end
    end
  endtask

  task automatic test_baud();
    int stamps[$];
    int d, span;
    logic [7:0] v;
    do_reset();
    for (int t = 0; t < 4; t++) begin
      d = (t == 0) ? 3 : ((t == 1) ? 0 : int'($urandom_range(1, 9)));
      bus_wr(2'd2, 8'(d));
      bus_wr(2'd3, 8'h00);
      stamps.delete();
      span = 4 * (d + 1) + 6;
      for (int k = 0; k < span; k++) begin
        if (baud_en === 1'b1) stamps.push_back(k);
        idle(1);
      end
      n_cmp++;
      if (stamps.size() < 3 || stamps[0] > 5 || stamps[0] > d + 1) begin
        n_bad++; $display("FAIL baud_start d=%0d: got %0d pulses, first at %0d", d, stamps.size(),
                          (stamps.size() > 0) ? stamps[0] : -1);
      end else begin
        for (int k = 1; k < stamps.size(); k++) begin
          n_cmp++;
          if (stamps[k] - stamps[k-1] != d + 1) begin
            n_bad++; $display("FAIL baud_period d=%0d: got %0d want %0d", d, stamps[k] - stamps[k-1], d + 1);
          end
        end
      end
      bus_rd(2'd2, v);
      n_cmp++; if (v !== m_div[7:0])  begin n_bad++; $display("FAIL baud_db_lo: got %h want %h", v, m_div[7:0]); end
      bus_rd(2'd3, v);
      n_cmp++; if (v !== m_div[15:8]) begin n_bad++; $display("FAIL baud_db_hi: got %h want %h", v, m_div[15:8]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    do_reset();
    tx_busy = 1'b1;
    for (int k = 0; k < 3; k++) bus_wr(2'd0, 8'($urandom));
    rx_pulse(8'h5A);
    rx_pulse(8'hA5);
    do_reset();
    n_cmp++; if (rda !== 1'b0) begin n_bad++; $display("FAIL mid_reset_rda: got %b want 0", rda); end
    n_cmp++; if (tbr !== 1'b1) begin n_bad++; $display("FAIL mid_reset_tbr: got %b want 1", tbr); end
    tx_busy = 1'b0;
    idle(10);
    n_cmp++;
    if (tx_seen.size() != 0) begin n_bad++; $display("FAIL mid_reset_tx: got %0d starts want 0", tx_seen.size()); end
    bus_rd(2'd0, v);
    n_cmp++; if (v !== 8'h00) begin n_bad++; $display("FAIL mid_reset_rx: got %h want 00", v); end
  endtask

  initial begin
    rst = 1'b0; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'd0; wdata = 8'h00;
    tx_busy = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    @(posedge clk); #1;
    test_reset();
    test_tx_basic();
    test_tx_full();
    test_back_to_back();
    test_tx_random();
    test_rx_overrun();
    test_rx_same_edge();
    test_rx_random();
    test_baud();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
